// File: rtl/shape_sequence_ctrl.sv
// Button sequencer: debounces btnU/btnD and steps a wrapping shape index that reaches the display only at frame_start.
// Step latency is 2 + DEBOUNCE_CYCLES; no backpressure. Optional auto-repeat via `AUTO_REPEAT_EN.
module shape_sequence_ctrl #(
   parameter int DEBOUNCE_CYCLES = 20_000_000,
   parameter int NUM_STATES      = 8,
   parameter int IDX_W           = 3,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD   = 25_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btnU,
   input  logic             btnD,
   input  logic             frame_start,
   output logic [IDX_W-1:0] shape_idx,
   output logic [IDX_W-1:0] pending_idx,
   output logic             doughnut_sel,
   output logic             step_pulse,
   output logic             update_pend
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_STATES - 1);

   if (((1 << IDX_W) < NUM_STATES) || (DEBOUNCE_CYCLES < 2) ||
       (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_cfg_err
      $error("shape_sequence_ctrl: illegal parameter combination");
   end

   typedef enum logic [1:0] {IDLE, QUAL, HELD, BLOCKED} state_t;

   state_t           state, state_nx;
   logic             u_meta, u, d_meta, d;
   logic [1:0]       sync_fill;
   logic             armed, armed_nx;
   logic             dir_up, dir_up_nx;
   logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
   logic             step, step_up;
   logic             own_btn, other_btn;

   assign cnt_inc   = cnt + CNT_W'(1);
   assign own_btn   = dir_up ? u : d;
   assign other_btn = dir_up ? d : u;

`ifdef AUTO_REPEAT_EN
   localparam int REP_W = $clog2(((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
   logic [REP_W-1:0] rep_cnt, rep_cnt_nx, rep_inc, rep_lim;
   logic             rep_after, rep_after_nx;

   assign rep_inc = rep_cnt + REP_W'(1);
   assign rep_lim = rep_after ? REP_W'(REPEAT_PERIOD) : REP_W'(REPEAT_DELAY);

   always_ff @(posedge clk) begin
      if (rst) begin
         rep_cnt   <= '0;
         rep_after <= 1'b0;
      end else begin
         rep_cnt   <= rep_cnt_nx;
         rep_after <= rep_after_nx;
      end
   end
`endif

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      armed_nx  = armed;
      dir_up_nx = dir_up;
      step      = 1'b0;
      step_up   = dir_up;
`ifdef AUTO_REPEAT_EN
      rep_cnt_nx   = rep_cnt;
      rep_after_nx = rep_after;
`endif
      case (state)
         IDLE: begin
            cnt_nx = '0;
            // After reset a button must be seen released before any press counts.
            if (!armed) begin
               if (sync_fill[1] && !u && !d) armed_nx = 1'b1;
            end else if (u && d) begin
               state_nx = BLOCKED;
            end else if (u ^ d) begin
               state_nx  = QUAL;
               dir_up_nx = u;
            end
         end
         QUAL: begin
            if (!own_btn || other_btn) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               step     = 1'b1;
               state_nx = HELD;
               cnt_nx   = '0;
`ifdef AUTO_REPEAT_EN
               rep_cnt_nx   = '0;
               rep_after_nx = 1'b0;
`endif
            end else begin
               cnt_nx = cnt_inc;
            end
         end
         HELD, BLOCKED: begin
            if (u || d)
               cnt_nx = '0;
            else if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES))
               state_nx = IDLE;
            else
               cnt_nx = cnt_inc;
`ifdef AUTO_REPEAT_EN
            if (state == HELD) begin
               if (other_btn) begin
                  state_nx     = BLOCKED;
                  cnt_nx       = '0;
                  rep_cnt_nx   = '0;
                  rep_after_nx = 1'b0;
               end else if (own_btn) begin
                  if (rep_inc == rep_lim) begin
                     step         = 1'b1;
                     rep_cnt_nx   = '0;
                     rep_after_nx = 1'b1;
                  end else begin
                     rep_cnt_nx = rep_inc;
                  end
               end else begin
                  rep_cnt_nx   = '0;
                  rep_after_nx = 1'b0;
               end
            end
`endif
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         u_meta       <= 1'b0;
         u            <= 1'b0;
         d_meta       <= 1'b0;
         d            <= 1'b0;
         sync_fill    <= '0;
         armed        <= 1'b0;
         state        <= IDLE;
         cnt          <= '0;
         dir_up       <= 1'b0;
         step_pulse   <= 1'b0;
         pending_idx  <= '0;
         shape_idx    <= '0;
         doughnut_sel <= 1'b0;
      end else begin
         u_meta     <= btnU;
         u          <= u_meta;
         d_meta     <= btnD;
         d          <= d_meta;
         sync_fill  <= {sync_fill[0], 1'b1};
         armed      <= armed_nx;
         state      <= state_nx;
         cnt        <= cnt_nx;
         dir_up     <= dir_up_nx;
         step_pulse <= step;
         if (step) begin
            if (step_up)
               pending_idx <= (pending_idx == IDX_MAX) ? '0 : pending_idx + IDX_W'(1);
            else
               pending_idx <= (pending_idx == '0) ? IDX_MAX : pending_idx - IDX_W'(1);
         end
         // Pre-step pending value is taken when a step lands on the frame edge.
         if (frame_start) shape_idx <= pending_idx;
         doughnut_sel <= (32'(shape_idx) >= 32'd4) && (32'(shape_idx) <= 32'd6);
      end
   end

   assign update_pend = (pending_idx != shape_idx);

endmodule

// File: tb/tb_shape_sequence_ctrl.sv
// Bench for shape_sequence_ctrl: directed button stimulus, scoreboard of expected steps checked by a monitor.
module tb_shape_sequence_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btnU = 1'b0;
   logic       btnD = 1'b0;
   logic       frame_start = 1'b0;
   logic [2:0] shape_idx, pending_idx;
   logic       doughnut_sel, step_pulse, update_pend;

   typedef struct {
      logic [2:0] idx;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   shape_sequence_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .NUM_STATES     (8),
      .IDX_W          (3),
      .REPEAT_DELAY   (10),
      .REPEAT_PERIOD  (5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btnU        (btnU),
      .btnD        (btnD),
      .frame_start (frame_start),
      .shape_idx   (shape_idx),
      .pending_idx (pending_idx),
      .doughnut_sel(doughnut_sel),
      .step_pulse  (step_pulse),
      .update_pend (update_pend)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every step_pulse must match the next queued expectation.
   always @(negedge clk) begin
      if (!rst && step_pulse) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_step cyc=%0d pending_idx=%0d required=no step", cyc, pending_idx);
         end else begin
            mon_e = exp_q.pop_front();
            if (pending_idx !== mon_e.idx || (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
               bad++;
               $display("FAIL step cyc=%0d pending_idx=%0d required cyc=%0d pending_idx=%0d",
                        cyc, pending_idx, mon_e.cyc, mon_e.idx);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic expect_step(input logic [2:0] idx, input int at_cyc);
      exp_t e;
      e.idx = idx;
      e.cyc = at_cyc;
      exp_q.push_back(e);
   endtask

   // Clean press of one button: held for hold cycles, then a full release.
   task automatic press(input bit up, input logic [2:0] idx, input int hold);
      expect_step(idx, cyc + 6);
      if (up) btnU = 1'b1; else btnD = 1'b1;
      tick(hold);
      btnU = 1'b0;
      btnD = 1'b0;
      tick(10);
   endtask

   task automatic frame_pulse();
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
   endtask

   initial begin
      tick(3);
      check("rst_shape_idx", shape_idx, 0);
      check("rst_pending_idx", pending_idx, 0);
      check("rst_doughnut_sel", doughnut_sel, 0);
      check("rst_step_pulse", step_pulse, 0);
      check("rst_update_pend", update_pend, 0);
      rst = 1'b0;
      tick(4);

      // Single press, no frame yet
      press(1'b1, 3'd1, 20);
      check("t1_pending", pending_idx, 1);
      check("t1_shape", shape_idx, 0);
      check("t1_update_pend", update_pend, 1);

      // Frame applies pending index
      frame_pulse();
      check("t2_shape", shape_idx, 1);
      check("t2_update_pend", update_pend, 0);
      tick(1);
      check("t2_doughnut", doughnut_sel, 0);

      // Step up to 5, apply, doughnut follows one cycle later
      for (int i = 2; i <= 5; i++) press(1'b1, 3'(i), 8);
      frame_pulse();
      check("t3_shape5", shape_idx, 5);
      check("t3_doughnut_lag", doughnut_sel, 0);
      tick(1);
      check("t3_doughnut5", doughnut_sel, 1);
      press(1'b1, 3'd6, 8);
      press(1'b1, 3'd7, 8);
      frame_pulse();
      tick(1);
      check("t3_shape7", shape_idx, 7);
      check("t3_doughnut7", doughnut_sel, 0);

      // Wrap up 7->0, then wrap down 0->7 with frame_start on the step edge
      press(1'b1, 3'd0, 8);
      check("t3_wrap_up", pending_idx, 0);
      check("t3_wrap_up_pend", update_pend, 1);
      frame_pulse();
      expect_step(3'd7, cyc + 6);
      btnD = 1'b1;
      tick(5);
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
      check("t3_wrap_down", pending_idx, 7);
      check("t3_same_edge_shape", shape_idx, 0);
      check("t3_same_edge_pend", update_pend, 1);
      tick(4);
      btnD = 1'b0;
      tick(10);
      frame_pulse();
      check("t3_frame_after", shape_idx, 7);

      // Glitch and both-pressed: no steps
      btnU = 1'b1;
      tick(2);
      btnU = 1'b0;
      tick(10);
      btnU = 1'b1;
      btnD = 1'b1;
      tick(30);
      btnU = 1'b0;
      btnD = 1'b0;
      tick(2);
      btnU = 1'b1;
      tick(10);
      btnU = 1'b0;
      tick(10);
      check("t4_no_step_pending", pending_idx, 7);
      press(1'b1, 3'd0, 8);
      check("t4_resume", pending_idx, 0);

      // Reset while held in HELD at index 5
      for (int i = 1; i <= 4; i++) press(1'b1, 3'(i), 8);
      expect_step(3'd5, cyc + 6);
      btnU = 1'b1;
      tick(8);
      check("t5_pre_rst", pending_idx, 5);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("t5_shape", shape_idx, 0);
      check("t5_pending", pending_idx, 0);
      check("t5_doughnut", doughnut_sel, 0);
      check("t5_step", step_pulse, 0);
      check("t5_update_pend", update_pend, 0);
      tick(20);
      btnU = 1'b0;
      tick(10);
      check("t5_still_held", pending_idx, 0);
      press(1'b1, 3'd1, 8);

      // Long hold from index 1
      begin
         int p;
         p = cyc;
`ifdef AUTO_REPEAT_EN
         expect_step(3'd2, p + 6);
         expect_step(3'd3, p + 16);
         expect_step(3'd4, p + 21);
         expect_step(3'd5, p + 26);
         expect_step(3'd6, p + 31);
         expect_step(3'd7, p + 36);
         expect_step(3'd0, p + 41);
`else
         expect_step(3'd2, p + 6);
`endif
         btnU = 1'b1;
         tick(40);
         btnU = 1'b0;
         tick(15);
      end
`ifdef AUTO_REPEAT_EN
      check("t6_final", pending_idx, 0);
`else
      check("t6_final", pending_idx, 2);
`endif

      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
